// File: rtl/reset_seq_gen.sv
// Reset sequencer: holds OUT_RST_N low for HOLD_CYCLES, releases it, then waits
// (bounded by TIMEOUT_CYCLES) for the downstream domain to acknowledge release.
module reset_seq_gen #(
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic REQ,
  input  logic ACK_RST_N,
  output logic OUT_RST_N,
  output logic BUSY,
  output logic DONE,
  output logic TIMEOUT_ERR
);

  // state      | meaning
  // ST_IDLE    | downstream out of reset, waiting for REQ
  // ST_ASSERT  | OUT_RST_N held low, counting HOLD_CYCLES
  // ST_RELEASE | OUT_RST_N high, waiting for ack_s or timeout
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             done_nxt;
  logic             timeout_err_nxt;
  logic             ack_meta, ack_s;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= ACK_RST_N;
      ack_s    <= ack_meta;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    done_nxt        = 1'b0;
    timeout_err_nxt = TIMEOUT_ERR;
    case (state)
      ST_IDLE: begin
        if (REQ) begin
          state_nxt       = ST_ASSERT;
          cnt_nxt         = '0;
          timeout_err_nxt = 1'b0;
        end
      end
      ST_ASSERT: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = ST_RELEASE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        // ack is checked first so it wins over a same-edge timeout
        if (ack_s) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else if (cnt == TMO_LAST) begin
          state_nxt       = ST_IDLE;
          done_nxt        = 1'b1;
          timeout_err_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_ASSERT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // outputs are registered from next-state so they change with the state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_ASSERT;
      cnt         <= '0;
      OUT_RST_N   <= 1'b0;
      BUSY        <= 1'b1;
      DONE        <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      OUT_RST_N   <= (state_nxt != ST_ASSERT);
      BUSY        <= (state_nxt != ST_IDLE);
      DONE        <= done_nxt;
      TIMEOUT_ERR <= timeout_err_nxt;
    end
  end

endmodule

// File: tb/tb_reset_seq_gen.sv
// Directed bench for reset_seq_gen with HOLD_CYCLES=4, TIMEOUT_CYCLES=8, CNT_W=4.
// Expected outputs are packed as {OUT_RST_N, BUSY, DONE, TIMEOUT_ERR}.
module tb_reset_seq_gen;

  logic CLK;
  logic RST;
  logic REQ;
  logic ACK_RST_N;
  logic OUT_RST_N;
  logic BUSY;
  logic DONE;
  logic TIMEOUT_ERR;

  logic ack_dly;
  logic ack_val;
  logic d1 = 1'b0;
  logic d2 = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       req;
    logic       ack_dly;
    logic       ack_val;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  reset_seq_gen #(
    .HOLD_CYCLES   (4),
    .TIMEOUT_CYCLES(8),
    .CNT_W         (4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ        (REQ),
    .ACK_RST_N  (ACK_RST_N),
    .OUT_RST_N  (OUT_RST_N),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // downstream domain model: OUT_RST_N delayed by two clocks, or forced
  always @(posedge CLK) begin
    d1 <= OUT_RST_N;
    d2 <= d1;
  end
  assign ACK_RST_N = ack_dly ? d2 : ack_val;

  task automatic check(input string name, input logic [3:0] exp);
    logic [3:0] got;
    got = {OUT_RST_N, BUSY, DONE, TIMEOUT_ERR};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: out/busy/done/terr got %b expected %b", name, got, exp);
    end
  endtask

  task automatic step(input logic req, input logic dly, input logic val,
                      input logic [3:0] exp, input string name);
    REQ     = req;
    ack_dly = dly;
    ack_val = val;
    @(posedge CLK);
    #1;
    check(name, exp);
  endtask

  task automatic add_n(input int n, input logic req, input logic dly,
                       input logic val, input logic [3:0] exp);
    for (int i = 0; i < n; i++) vecs.push_back('{req, dly, val, exp});
  endtask

  initial begin
    RST     = 1'b0;
    REQ     = 1'b0;
    ack_dly = 1'b1;
    ack_val = 1'b0;

    // power-on sequence, delayed ack
    add_n(3, 0, 1, 0, 4'b0100);
    add_n(5, 0, 1, 0, 4'b1100);
    add_n(1, 0, 1, 0, 4'b1010);
    add_n(2, 0, 1, 0, 4'b1000);
    // single-cycle REQ from IDLE
    add_n(1, 1, 1, 0, 4'b0100);
    add_n(3, 0, 1, 0, 4'b0100);
    add_n(5, 0, 1, 0, 4'b1100);
    add_n(1, 0, 1, 0, 4'b1010);
    add_n(1, 0, 1, 0, 4'b1000);
    // ack tied low: timeout 8 cycles after release, error sticky
    add_n(3, 0, 0, 0, 4'b1000);
    add_n(1, 1, 0, 0, 4'b0100);
    add_n(3, 0, 0, 0, 4'b0100);
    add_n(8, 0, 0, 0, 4'b1100);
    add_n(1, 0, 0, 0, 4'b1011);
    add_n(2, 0, 0, 0, 4'b1001);
    // next REQ clears the error; REQ in 2nd ASSERT cycle ignored
    add_n(1, 1, 1, 0, 4'b0100);
    add_n(1, 1, 1, 0, 4'b0100);
    add_n(2, 0, 1, 0, 4'b0100);
    add_n(5, 0, 1, 0, 4'b1100);
    add_n(1, 0, 1, 0, 4'b1010);
    add_n(1, 0, 1, 0, 4'b1000);
    // ack_s rises on the edge cnt reaches 7: ack wins over timeout
    add_n(3, 0, 0, 0, 4'b1000);
    add_n(1, 1, 0, 0, 4'b0100);
    add_n(3, 0, 0, 0, 4'b0100);
    add_n(6, 0, 0, 0, 4'b1100);
    add_n(2, 0, 0, 1, 4'b1100);
    add_n(1, 0, 0, 1, 4'b1010);
    add_n(1, 0, 0, 1, 4'b1000);

    #1 RST = 1'b1;
    #1 check("reset_async", 4'b0100);
    repeat (2) @(posedge CLK);
    #1 check("reset_hold", 4'b0100);
    #2 RST = 1'b0;

    foreach (vecs[i])
      step(vecs[i].req, vecs[i].ack_dly, vecs[i].ack_val, vecs[i].exp,
           $sformatf("vec[%0d]", i));

    // RST in the 2nd RELEASE cycle, mid-cycle, then a fresh sequence
    step(1, 1, 0, 4'b0100, "abort_req");
    repeat (3) step(0, 1, 0, 4'b0100, "abort_assert");
    repeat (2) step(0, 1, 0, 4'b1100, "abort_release");
    #3 RST = 1'b1;
    #1 check("abort_async", 4'b0100);
    repeat (3) begin
      @(posedge CLK);
      #1 check("abort_hold", 4'b0100);
    end
    #2 RST = 1'b0;
    repeat (3) step(0, 1, 0, 4'b0100, "rerun_assert");
    repeat (5) step(0, 1, 0, 4'b1100, "rerun_release");
    step(0, 1, 0, 4'b1010, "rerun_done");
    step(0, 1, 0, 4'b1000, "rerun_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
